// File: rtl/tile_fetcher.sv
// Tile fetcher: walks a 32-tile line, reading a code byte and an attribute byte per tile.
// Optional `TILE_FETCHER_FLIP_EN adds a flip input that mirrors row/col in RAM addresses.
module tile_fetcher #(
  parameter int unsigned addr_width_g = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    line_start,
  input  logic [4:0]              vrow,
`ifdef TILE_FETCHER_FLIP_EN
  input  logic                    flip,
`endif
  output logic                    ram_en,
  output logic [addr_width_g-1:0] ram_addr,
  input  logic [7:0]              ram_q,
  output logic                    tile_valid,
  input  logic                    tile_ready,
  output logic [4:0]              tile_col,
  output logic [7:0]              tile_code,
  output logic [7:0]              tile_attr,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {StIdle, StRdCode, StRdAttr, StLat, StHold} state_e;

  state_e                  state_q, state_d;
  logic [4:0]              row_q, row_d;
  logic [4:0]              col_q, col_d;
  logic [7:0]              code_q, code_d;
  logic [7:0]              attr_q, attr_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    ram_en_q, ram_en_d;
  logic [addr_width_g-1:0] ram_addr_q, ram_addr_d;
  logic [4:0]              arow, acol;
`ifdef TILE_FETCHER_FLIP_EN
  logic                    flip_q, flip_d;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    code_d  = code_q;
    attr_d  = attr_q;
    done_d  = 1'b0;
`ifdef TILE_FETCHER_FLIP_EN
    flip_d  = flip_q;
`endif
    // A new line_start restarts from any state, abandoning the line without done.
    if (line_start) begin
      state_d = StRdCode;
      row_d   = vrow;
      col_d   = 5'd0;
`ifdef TILE_FETCHER_FLIP_EN
      flip_d  = flip;
`endif
    end else begin
      case (state_q)
        StIdle:   state_d = StIdle;
        StRdCode: state_d = StRdAttr;
        StRdAttr: begin
          state_d = StLat;
          code_d  = ram_q;
        end
        StLat: begin
          state_d = StHold;
          attr_d  = ram_q;
        end
        StHold: begin
          if (tile_ready) begin
            if (col_q == 5'd31) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StRdCode;
              col_d   = col_q + 5'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered, so they are derived from the next state.
    busy_d   = (state_d != StIdle);
    valid_d  = (state_d == StHold);
    ram_en_d = (state_d == StRdCode) || (state_d == StRdAttr);
`ifdef TILE_FETCHER_FLIP_EN
    arow = flip_d ? ~row_d : row_d;
    acol = flip_d ? ~col_d : col_d;
`else
    arow = row_d;
    acol = col_d;
`endif
    ram_addr_d                   = '0;
    ram_addr_d[4:0]              = acol;
    ram_addr_d[9:5]              = arow;
    ram_addr_d[addr_width_g-1]   = (state_d == StRdAttr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      row_q      <= 5'd0;
      col_q      <= 5'd0;
      code_q     <= 8'h00;
      attr_q     <= 8'h00;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
`ifdef TILE_FETCHER_FLIP_EN
      flip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      code_q     <= code_d;
      attr_q     <= attr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
`ifdef TILE_FETCHER_FLIP_EN
      flip_q     <= flip_d;
`endif
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_addr   = ram_addr_q;
  assign tile_valid = valid_q;
  assign tile_col   = col_q;
  assign tile_code  = code_q;
  assign tile_attr  = attr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
